// File: rtl/watch_set_ctrl_pkg.sv
// Shared types and default timing for the watch time-setting controller.
// Defaults assume a 50 MHz clock.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_SET_HH = 2'd1,
    MODE_SET_MM = 2'd2,
    MODE_SET_SS = 2'd3
  } watch_mode_e;

  localparam int LONG_CYCLES_DEF    = 50_000_000;
  localparam int REPEAT_CYCLES_DEF  = 10_000_000;
  localparam int TIMEOUT_CYCLES_DEF = 500_000_000;
  localparam int BLINK_CYCLES_DEF   = 12_500_000;

  // One width for every counter: wide enough for the largest period plus a spare bit.
  function automatic int cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/watch_set_ctrl_if.sv
// Key inputs and timekeeper/display outputs of the time-setting controller.
interface watch_set_ctrl_if;
  logic       key_mode_i;
  logic       key_up_i;
  logic [1:0] mode_o;
  logic       run_en_o;
  logic       inc_o;
  logic       sec_clr_o;
  logic       blink_o;

  modport master (
    output key_mode_i, key_up_i,
    input  mode_o, run_en_o, inc_o, sec_clr_o, blink_o
  );

  modport slave (
    input  key_mode_i, key_up_i,
    output mode_o, run_en_o, inc_o, sec_clr_o, blink_o
  );
endinterface

// File: rtl/watch_set_ctrl_key_hold_timer.sv
// Per-key edge detector with long-press auto-repeat.
// rise/rep are combinational from registers; the caller registers the strobes it derives.
module key_hold_timer
  import watch_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CW            = cnt_w(LONG_CYCLES, REPEAT_CYCLES, 1, 1)
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic key,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic rep
);

  localparam logic [CW-1:0] LONG_M1 = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_M1  = CW'(REPEAT_CYCLES - 1);

  logic          key_q, key_prev, primed, armed;
  logic [CW-1:0] hold_cnt, rep_cnt;

  // primed only sets once the key has been seen low, so a key held through reset never rises
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      key_q    <= 1'b0;
      key_prev <= 1'b0;
      primed   <= 1'b0;
    end else begin
      key_q    <= key;
      key_prev <= key_q;
      primed   <= primed | ~key;
    end
  end

  assign level = key_q;
  assign rise  = key_q & ~key_prev & primed;
  assign rep   = armed & key_q & (hold_cnt == LONG_M1) & (rep_cnt == '0);

  // hold_cnt saturates at LONG-1; rep_cnt then paces the repeat period
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      armed    <= 1'b0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (clr || !key_q) begin
      armed    <= 1'b0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (rise) begin
      armed    <= 1'b1;
      hold_cnt <= CW'(1);
      rep_cnt  <= '0;
    end else if (armed) begin
      if (hold_cnt != LONG_M1)  hold_cnt <= hold_cnt + CW'(1);
      else if (rep_cnt == REP_M1) rep_cnt <= '0;
      else                        rep_cnt <= rep_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting controller: mode FSM, inc/sec-clear strobes with auto-repeat,
// idle timeout back to RUN and blink of the field being edited.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int LONG_CYCLES    = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES  = REPEAT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int BLINK_CYCLES   = BLINK_CYCLES_DEF
) (
  input logic             clk_i,
  input logic             rstn_i,
  watch_set_ctrl_if.slave bus
);

  localparam int CW = cnt_w(LONG_CYCLES, REPEAT_CYCLES, TIMEOUT_CYCLES, BLINK_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] BLINK_M1   = CW'(BLINK_CYCLES - 1);

  logic          mode_lvl, mode_rise, mode_rep_unused;
  logic          up_lvl, up_rise, up_rep;
  logic          in_set, timeout, mode_chg;
  watch_mode_e   mode_q, mode_d;
  logic          inc_q, inc_d, clr_q, clr_d, blink_q, blink_d;
  logic [CW-1:0] idle_q, idle_d, blink_cnt_q, blink_cnt_d;

  key_hold_timer #(
    .LONG_CYCLES(LONG_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .CW(CW)
  ) u_mode_key (
    .clk_i(clk_i), .rstn_i(rstn_i), .key(bus.key_mode_i), .clr(mode_chg),
    .level(mode_lvl), .rise(mode_rise), .rep(mode_rep_unused)
  );

  key_hold_timer #(
    .LONG_CYCLES(LONG_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .CW(CW)
  ) u_up_key (
    .clk_i(clk_i), .rstn_i(rstn_i), .key(bus.key_up_i), .clr(mode_chg),
    .level(up_lvl), .rise(up_rise), .rep(up_rep)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_q      <= MODE_RUN;
      inc_q       <= 1'b0;
      clr_q       <= 1'b0;
      blink_q     <= 1'b1;
      idle_q      <= '0;
      blink_cnt_q <= '0;
    end else begin
      mode_q      <= mode_d;
      inc_q       <= inc_d;
      clr_q       <= clr_d;
      blink_q     <= blink_d;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // Priority: timeout, then MODE, then UP; a mode change always swallows the UP strobe
  always_comb begin
    mode_d  = mode_q;
    inc_d   = 1'b0;
    clr_d   = 1'b0;
    in_set  = (mode_q != MODE_RUN);
    timeout = in_set && !(mode_lvl || up_lvl) && (idle_q >= TIMEOUT_M1);
    if (timeout) begin
      mode_d = MODE_RUN;
    end else if (mode_rise) begin
      mode_d = watch_mode_e'(mode_q + 2'd1);
    end else if (in_set && (up_rise || up_rep)) begin
      if (mode_q == MODE_SET_SS) clr_d = up_rise;
      else                       inc_d = 1'b1;
    end
    mode_chg = (mode_d != mode_q);
  end

  always_comb begin
    idle_d = idle_q;
    if (!in_set || mode_chg || mode_lvl || up_lvl) idle_d = '0;
    else if (idle_q < TIMEOUT_M1)                 idle_d = idle_q + CW'(1);
  end

  // Blink phase restarts at 1 on every mode change
  always_comb begin
    blink_cnt_d = blink_cnt_q + CW'(1);
    blink_d     = blink_q;
    if (mode_chg || !in_set) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_M1) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  assign bus.mode_o    = mode_q;
  assign bus.run_en_o  = (mode_q == MODE_RUN);
  assign bus.inc_o     = inc_q;
  assign bus.sec_clr_o = clr_q;
  assign bus.blink_o   = blink_q;

endmodule
